// File: rtl/csr_spi_pkg.sv
// Shared constants and FSM state type for the SPI-to-CSR bridge.
package csr_spi_pkg;

    localparam int FRAME_BITS  = 16;  // R/W bit + address + data
    localparam int CMD_BITS    = 8;   // R/W bit + address
    localparam int BIT_CNT_W   = 5;   // counts 0..FRAME_BITS
    localparam int HOLD_CNT_W  = 4;   // strobe hold counter, up to 16 cycles
    localparam int ABORT_CNT_W = 8;   // aborted-frame counter width

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        RD_STROBE,
        WR_STROBE,
        DONE
    } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser plus one edge-detect flop for a single asynchronous SPI pin.
module spi_pin_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // [0],[1] synchronise, [2] holds the previous synchronised value for edge detection
    logic [2:0] sync_reg;

    // Shift the raw pin through the synchroniser chain
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= {3{RESET_VAL}};
        end else begin
            sync_reg <= {sync_reg[1:0], pin_i};
        end
    end

    assign level_o = sync_reg[1];
    assign rise_o  = (sync_reg[2:1] == 2'b01);
    assign fall_o  = (sync_reg[2:1] == 2'b10);

endmodule

// File: rtl/spi_csr_bridge.sv
// SPI slave (mode 0, MSB first) turning 16-bit frames into CSR read/write strobes.
// Optional build macro CSR_SPI_ABORT_CNT_EN adds a saturating aborted-frame counter.
module spi_csr_bridge
    import csr_spi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 8,
    parameter int WR_HOLD_CYCLES = 4,
    parameter int RD_HOLD_CYCLES = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic                   spi_sclk_i,
    input  logic                   spi_cs_n_i,
    input  logic                   spi_mosi_i,
    output logic                   spi_miso_o,
    output logic                   spi_miso_oe_o,
    output logic [ADDR_WIDTH-1:0]  addr_o,
    output logic [DATA_WIDTH-1:0]  write_data_o,
    output logic                   write_en_o,
    output logic                   read_en_o,
    input  logic [DATA_WIDTH-1:0]  read_data_i,
    output logic [ABORT_CNT_W-1:0] abort_cnt_o
);

    localparam logic [BIT_CNT_W-1:0]  CNT_CMD   = BIT_CNT_W'(CMD_BITS);
    localparam logic [BIT_CNT_W-1:0]  CNT_FRAME = BIT_CNT_W'(FRAME_BITS);
    localparam logic [HOLD_CNT_W-1:0] WR_LAST   = HOLD_CNT_W'(WR_HOLD_CYCLES - 1);
    localparam logic [HOLD_CNT_W-1:0] RD_LAST   = HOLD_CNT_W'(RD_HOLD_CYCLES - 1);
    // Pin order {mosi, cs_n, sclk}; cs_n idles high so its synchroniser resets to 1
    localparam logic [2:0] PIN_RST = 3'b010;

    logic [2:0] pin_raw, pin_lvl, pin_rise, pin_fall;

    assign pin_raw = {spi_mosi_i, spi_cs_n_i, spi_sclk_i};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            spi_pin_sync #(
                .RESET_VAL (PIN_RST[gi])
            ) u_sync (
                .clk_i   (clk_i),
                .rst_n   (rst_n),
                .pin_i   (pin_raw[gi]),
                .level_o (pin_lvl[gi]),
                .rise_o  (pin_rise[gi]),
                .fall_o  (pin_fall[gi])
            );
        end
    endgenerate

    logic sclk_rise, sclk_fall, cs_lvl, cs_fall, mosi_lvl;
    assign sclk_rise = pin_rise[0];
    assign sclk_fall = pin_fall[0];
    assign cs_lvl    = pin_lvl[1];
    assign cs_fall   = pin_fall[1];
    assign mosi_lvl  = pin_lvl[2];

    logic unused_pins;
    assign unused_pins = &{1'b0, pin_lvl[0], pin_rise[1], pin_rise[2], pin_fall[2]};

    state_t                  state_reg, state_next;
    logic [BIT_CNT_W-1:0]    bit_cnt_reg, bit_cnt_next, cnt_inc;
    logic [HOLD_CNT_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [FRAME_BITS-2:0]   rx_reg, rx_next;
    logic [FRAME_BITS-1:0]   rx_shift;
    logic [FRAME_BITS-1:0]   tx_reg, tx_next;
    logic [DATA_WIDTH-1:0]   rd_shadow_reg, rd_shadow_next;
    logic                    rd_done_reg, rd_done_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
    logic                    write_en_reg, write_en_next;
    logic                    read_en_reg, read_en_next;
    logic                    abort_evt;

    // Next-state and datapath decisions for the frame FSM
    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        hold_cnt_next  = hold_cnt_reg;
        rx_next        = rx_reg;
        tx_next        = tx_reg;
        rd_shadow_next = rd_shadow_reg;
        rd_done_next   = rd_done_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        abort_evt      = 1'b0;
        rx_shift       = {rx_reg, mosi_lvl};
        cnt_inc        = bit_cnt_reg + BIT_CNT_W'(1);

        case (state_reg)
            IDLE: begin
                if (cs_fall) begin
                    state_next   = SHIFT;
                    bit_cnt_next = '0;
                    rx_next      = '0;
                    rd_done_next = 1'b0;
                    tx_next      = {{(FRAME_BITS-DATA_WIDTH){1'b0}}, rd_shadow_reg};
                end
            end
            SHIFT: begin
                if (cs_lvl) begin
                    // A read whose strobe already fired ends cleanly; anything else is cut short
                    state_next = IDLE;
                    abort_evt  = !rd_done_reg;
                end else begin
                    if (sclk_fall) begin
                        tx_next = {tx_reg[FRAME_BITS-2:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        rx_next      = rx_shift[FRAME_BITS-2:0];
                        bit_cnt_next = cnt_inc;
                        if (cnt_inc == CNT_CMD && !rx_shift[CMD_BITS-1]) begin
                            addr_next     = rx_shift[CMD_BITS-2 -: ADDR_WIDTH];
                            rd_done_next  = 1'b1;
                            hold_cnt_next = '0;
                            state_next    = RD_STROBE;
                        end else if (cnt_inc == CNT_FRAME) begin
                            if (rx_shift[FRAME_BITS-1]) begin
                                addr_next     = rx_shift[FRAME_BITS-2 -: ADDR_WIDTH];
                                wdata_next    = rx_shift[DATA_WIDTH-1:0];
                                hold_cnt_next = '0;
                                state_next    = WR_STROBE;
                            end else begin
                                state_next = DONE;
                            end
                        end
                    end
                end
            end
            RD_STROBE: begin
                // MISO keeps moving while the read is outstanding
                if (sclk_fall) begin
                    tx_next = {tx_reg[FRAME_BITS-2:0], 1'b0};
                end
                if (hold_cnt_reg == RD_LAST) begin
                    rd_shadow_next = read_data_i;
                    state_next     = cs_lvl ? IDLE : SHIFT;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HOLD_CNT_W'(1);
                end
            end
            WR_STROBE: begin
                if (hold_cnt_reg == WR_LAST) begin
                    state_next = cs_lvl ? IDLE : DONE;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HOLD_CNT_W'(1);
                end
            end
            DONE: begin
                if (cs_lvl) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Strobes are registered so downstream synchronisers never see decode glitches
        write_en_next = (state_next == WR_STROBE);
        read_en_next  = (state_next == RD_STROBE);
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            hold_cnt_reg  <= '0;
            rx_reg        <= '0;
            tx_reg        <= '0;
            rd_shadow_reg <= '0;
            rd_done_reg   <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            write_en_reg  <= 1'b0;
            read_en_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            hold_cnt_reg  <= hold_cnt_next;
            rx_reg        <= rx_next;
            tx_reg        <= tx_next;
            rd_shadow_reg <= rd_shadow_next;
            rd_done_reg   <= rd_done_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            write_en_reg  <= write_en_next;
            read_en_reg   <= read_en_next;
        end
    end

`ifdef CSR_SPI_ABORT_CNT_EN
    logic [ABORT_CNT_W-1:0] abort_cnt_reg;

    // Saturating count of frames cut short by cs_n
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            abort_cnt_reg <= '0;
        end else if (abort_evt && (abort_cnt_reg != '1)) begin
            abort_cnt_reg <= abort_cnt_reg + ABORT_CNT_W'(1);
        end
    end

    assign abort_cnt_o = abort_cnt_reg;
`else
    logic unused_abort;
    assign unused_abort = abort_evt;
    assign abort_cnt_o  = '0;
`endif

    assign spi_miso_o    = tx_reg[FRAME_BITS-1];
    assign spi_miso_oe_o = !cs_lvl;
    assign addr_o        = addr_reg;
    assign write_data_o  = wdata_reg;
    assign write_en_o    = write_en_reg;
    assign read_en_o     = read_en_reg;

endmodule

// File: tb/tb_spi_csr_bridge.sv
// Directed testbench for spi_csr_bridge: SPI master stimulus, CSR register model,
// strobe scoreboards and MISO expectations.
module tb_spi_csr_bridge;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_sclk_i = 1'b0;
    logic       spi_cs_n_i = 1'b1;
    logic       spi_mosi_i = 1'b0;
    logic       spi_miso_o, spi_miso_oe_o;
    logic [6:0] addr_o;
    logic [7:0] write_data_o;
    logic       write_en_o, read_en_o;
    logic [7:0] read_data_i = 8'h00;
    logic [7:0] abort_cnt_o;

    int total = 0;
    int bad   = 0;

    wr_t        exp_wr_q[$];
    logic [6:0] exp_rd_q[$];
    logic [7:0] mem     [0:127];
    logic [7:0] ref_mem [0:127];
    logic [7:0] exp_shadow = 8'h00;
    logic [7:0] rd_pipe = 8'h00;
    logic       wr_prev_m = 1'b0;

    spi_csr_bridge dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .spi_sclk_i    (spi_sclk_i),
        .spi_cs_n_i    (spi_cs_n_i),
        .spi_mosi_i    (spi_mosi_i),
        .spi_miso_o    (spi_miso_o),
        .spi_miso_oe_o (spi_miso_oe_o),
        .addr_o        (addr_o),
        .write_data_o  (write_data_o),
        .write_en_o    (write_en_o),
        .read_en_o     (read_en_o),
        .read_data_i   (read_data_i),
        .abort_cnt_o   (abort_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Downstream register map: 64 registers, 2-cycle read latency, 0xFF above 0x3F
    always @(posedge clk_i) begin
        rd_pipe     <= (addr_o < 7'h40) ? mem[addr_o] : 8'hFF;
        read_data_i <= rd_pipe;
        wr_prev_m   <= write_en_o;
        if (write_en_o && !wr_prev_m) mem[addr_o] <= write_data_o;
    end

    // Write strobe monitor: length, stability and scoreboard match per pulse
    int         wr_len = 0;
    logic [6:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_stable = 1'b1;
    logic       wr_en_q = 1'b0;
    always @(negedge clk_i) begin
        if (write_en_o) begin
            if (!wr_en_q) begin
                wr_len = 0; wr_addr = addr_o; wr_data = write_data_o; wr_stable = 1'b1;
            end
            wr_len++;
            if (addr_o !== wr_addr || write_data_o !== wr_data) wr_stable = 1'b0;
        end else if (wr_en_q) begin
            total++;
            assert (exp_wr_q.size() > 0) else begin
                bad++;
                $error("FAIL wr_unexpected observed=pulse addr %0h data %0h expected=no pulse", wr_addr, wr_data);
            end
            if (exp_wr_q.size() > 0) begin
                wr_t e;
                e = exp_wr_q.pop_front();
                $display("write pulse addr=%0h data=%0h len=%0d", wr_addr, wr_data, wr_len);
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", 32'(wr_data), 32'(e.data));
                chk("wr_len", 32'(wr_len), 32'd4);
                chk("wr_stable", 32'(wr_stable), 32'd1);
            end
        end
        wr_en_q = write_en_o;
    end

    // Read strobe monitor: length and address per pulse
    int         rd_len = 0;
    logic [6:0] rd_addr = '0;
    logic       rd_en_q = 1'b0;
    always @(negedge clk_i) begin
        if (read_en_o) begin
            if (!rd_en_q) begin
                rd_len = 0; rd_addr = addr_o;
            end
            rd_len++;
        end else if (rd_en_q) begin
            total++;
            assert (exp_rd_q.size() > 0) else begin
                bad++;
                $error("FAIL rd_unexpected observed=pulse addr %0h expected=no pulse", rd_addr);
            end
            if (exp_rd_q.size() > 0) begin
                logic [6:0] ea;
                ea = exp_rd_q.pop_front();
                $display("read pulse addr=%0h len=%0d", rd_addr, rd_len);
                chk("rd_addr", 32'(rd_addr), 32'(ea));
                chk("rd_len", 32'(rd_len), 32'd3);
            end
        end
        rd_en_q = read_en_o;
    end

    // Mode-0 master: MOSI changes while SCLK low, MISO sampled at each rising edge
    task automatic spi_xfer(input logic [15:0] frame, input int nbits, input int half,
                            input bit keep_cs, output logic [15:0] miso_bits);
        miso_bits = '0;
        @(negedge clk_i);
        spi_cs_n_i = 1'b0;
        repeat (half) @(negedge clk_i);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi_i = frame[15-i];
            repeat (half) @(negedge clk_i);
            spi_sclk_i = 1'b1;
            miso_bits[15-i] = spi_miso_o;
            repeat (half) @(negedge clk_i);
            spi_sclk_i = 1'b0;
        end
        if (!keep_cs) begin
            repeat (half) @(negedge clk_i);
            spi_cs_n_i = 1'b1;
        end
    endtask

    // Full frame with scoreboard bookkeeping and MISO check
    task automatic send(input logic [15:0] f, input int half, input int gap, input string tag);
        logic [15:0] m;
        logic [15:0] exp_m;
        exp_m = {8'h00, exp_shadow};
        if (f[15]) begin
            exp_wr_q.push_back(wr_t'({f[14:8], f[7:0]}));
            ref_mem[f[14:8]] = f[7:0];
        end else begin
            exp_rd_q.push_back(f[14:8]);
            exp_shadow = (f[14:8] < 7'h40) ? ref_mem[f[14:8]] : 8'hFF;
        end
        spi_xfer(f, 16, half, 1'b0, m);
        $display("frame %s mosi=%04h miso=%04h", tag, f, m);
        chk(tag, 32'(m), 32'(exp_m));
        repeat (gap) @(negedge clk_i);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr"},  32'(addr_o), 32'd0);
        chk({tag, "_wdata"}, 32'(write_data_o), 32'd0);
        chk({tag, "_wen"},   32'(write_en_o), 32'd0);
        chk({tag, "_ren"},   32'(read_en_o), 32'd0);
        chk({tag, "_miso"},  32'(spi_miso_o), 32'd0);
        chk({tag, "_oe"},    32'(spi_miso_oe_o), 32'd0);
        chk({tag, "_abort"}, 32'(abort_cnt_o), 32'd0);
    endtask

    initial begin
        logic [15:0] junk;
        int          wait_cnt;
        logic [7:0]  exp_abort;
        for (int i = 0; i < 128; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
`ifdef CSR_SPI_ABORT_CNT_EN
        exp_abort = 8'd1;
`else
        exp_abort = 8'd0;
`endif
        // Reset state
        repeat (4) @(negedge clk_i);
        chk_reset_outputs("rst_hold");
        rst_n = 1'b1;
        repeat (4) @(negedge clk_i);
        chk_reset_outputs("rst_rel");

        // 1: write addr 3 = 0xA5
        send(16'h83A5, 8, 20, "t1_wr");
        chk("t1_addr_o", 32'(addr_o), 32'h03);
        chk("t1_wdata_o", 32'(write_data_o), 32'hA5);

        // 2: read addr 3, result returned in the next frame
        send(16'h0300, 8, 20, "t2_rd");
        send(16'h0000, 8, 20, "t2_dummy");

        // 3: out-of-range read returns 0xFF; follow-up reads addr 5
        send(16'h4000, 8, 20, "t3_rd");
        send(16'h0500, 8, 20, "t3_dummy");

        // 4: write aborted after 10 bits
        spi_xfer(16'h8A33, 10, 8, 1'b0, junk);
        repeat (20) @(negedge clk_i);
        $display("abort frame addr_o=%0h abort_cnt=%0d", addr_o, abort_cnt_o);
        chk("t4_addr_kept", 32'(addr_o), 32'h05);
        chk("t4_wdata_kept", 32'(write_data_o), 32'hA5);
        chk("t4_abort_cnt", 32'(abort_cnt_o), 32'(exp_abort));

        // 5: reset during bit 12 of a write, then a clean write
        spi_xfer(16'h8777, 11, 8, 1'b1, junk);
        spi_mosi_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t5_in_rst");
        exp_shadow = 8'h00;
        repeat (3) @(negedge clk_i);
        spi_cs_n_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_i);
        send(16'h8155, 8, 20, "t5_wr");
        chk("t5_mem1", 32'(mem[1]), 32'h55);

        // 6: back-to-back writes, SCLK = clk/8, 2-cycle cs_n gap
        send(16'h9011, 4, 2, "t6_wr_a");
        send(16'h9122, 4, 20, "t6_wr_b");
        chk("t6_mem10", 32'(mem[7'h10]), 32'h11);
        chk("t6_mem11", 32'(mem[7'h11]), 32'h22);

        // Read back over SPI what the earlier writes left behind
        send(16'h0100, 8, 20, "rb_rd1");
        send(16'h1000, 8, 20, "rb_rd10");
        send(16'h0000, 8, 20, "rb_dummy");

        // Every expected strobe must have been seen
        wait_cnt = 0;
        while ((exp_wr_q.size() != 0 || exp_rd_q.size() != 0) && wait_cnt < 500) begin
            @(negedge clk_i);
            wait_cnt++;
        end
        chk("wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
        chk("rd_q_empty", 32'(exp_rd_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
